csr_counter_ctrl: RTL and testbench



---
 rtl/csr_counter_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_csr_counter_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_ctrl.sv
// Machine/user counter CSR sequencer: owns the 64-bit cycle and instret counters
// and serves one read-modify-write CSR access at a time through IDLE/EXEC/RESP.
module csr_counter_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_req,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_mode,
  input  logic [31:0] csr_wdata,
  input  logic        instr_retire,
  output logic        csr_ready,
  output logic        csr_ack,
  output logic [31:0] csr_rdata,
  output logic        csr_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  typedef enum logic [2:0] {
    T_NONE,
    T_CYC_LO,
    T_CYC_HI,
    T_INS_LO,
    T_INS_HI,
    T_INH
  } target_t;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_SET   = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  state_t      state;
  logic [11:0] req_addr;
  logic [1:0]  req_mode;
  logic [31:0] req_wdata;

  logic [63:0] cyc;
  logic [63:0] ins;
  logic        inh_cy;
  logic        inh_ir;

  target_t     target;
  logic        read_only;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        do_write;
  logic        exec_err;
  logic        commit;
  logic        wr_cyc_lo;
  logic        wr_cyc_hi;
  logic        wr_ins_lo;
  logic        wr_ins_hi;
  logic        wr_inh;

  // NOTE: the captured request feeds only EXEC, which is always entered through the
  // capture edge, so these registers carry no reset and never expose a stale value.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && csr_req) begin
      req_addr  <= csr_addr;
      req_mode  <= csr_mode;
      req_wdata <= csr_wdata;
    end
  end

  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    target    = T_NONE;
    read_only = 1'b0;
    unique case (req_addr)
      12'hB00: target = T_CYC_LO;
      12'hB80: target = T_CYC_HI;
      12'hB02: target = T_INS_LO;
      12'hB82: target = T_INS_HI;
      12'hC00, 12'hC01: begin
        target    = T_CYC_LO;
        read_only = 1'b1;
      end
      12'hC80, 12'hC81: begin
        target    = T_CYC_HI;
        read_only = 1'b1;
      end
      12'hC02: begin
        target    = T_INS_LO;
        read_only = 1'b1;
      end
      12'hC82: begin
        target    = T_INS_HI;
        read_only = 1'b1;
      end
      12'h320: target = T_INH;
      default: target = T_NONE;
    endcase
  end

  always_comb begin
    old_val = 32'h0;
    unique case (target)
      T_CYC_LO: old_val = cyc[31:0];
      T_CYC_HI: old_val = cyc[63:32];
      T_INS_LO: old_val = ins[31:0];
      T_INS_HI: old_val = ins[63:32];
      T_INH:    old_val = {29'h0, inh_ir, 1'b0, inh_cy};
      default:  old_val = 32'h0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    unique case (req_mode)
      MODE_WRITE: new_val = req_wdata;
      MODE_SET:   new_val = old_val | req_wdata;
      MODE_CLEAR: new_val = old_val & ~req_wdata;
      default:    new_val = old_val;
    endcase
  end

  // Set/clear with a zero operand is a pure read, so it is legal on RO counters.
  assign do_write = (req_mode == MODE_WRITE) ||
                    ((req_mode == MODE_SET || req_mode == MODE_CLEAR) && (req_wdata != 32'h0));
  assign exec_err = (target == T_NONE) || (read_only && do_write);
  assign commit   = (state == S_EXEC) && do_write && !exec_err && (req_mode != MODE_READ);

  assign wr_cyc_lo = commit && (target == T_CYC_LO);
  assign wr_cyc_hi = commit && (target == T_CYC_HI);
  assign wr_ins_lo = commit && (target == T_INS_LO);
  assign wr_ins_hi = commit && (target == T_INS_HI);
  assign wr_inh    = commit && (target == T_INH);

  // A committed half-write replaces that edge's increment; the other half holds.
  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc    <= 64'h0;
      ins    <= 64'h0;
      inh_cy <= 1'b0;
      inh_ir <= 1'b0;
    end else begin
      if (wr_cyc_lo) begin
        cyc[31:0] <= new_val;
      end else if (wr_cyc_hi) begin
        cyc[63:32] <= new_val;
      end else if (!inh_cy) begin
        cyc <= cyc + 64'd1;
      end

      if (wr_ins_lo) begin
        ins[31:0] <= new_val;
      end else if (wr_ins_hi) begin
        ins[63:32] <= new_val;
      end else if (instr_retire && !inh_ir) begin
        ins <= ins + 64'd1;
      end

      if (wr_inh) begin
        inh_cy <= new_val[0];
        inh_ir <= new_val[2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      csr_ready <= 1'b1;
      csr_ack   <= 1'b0;
      csr_rdata <= 32'h0;
      csr_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (csr_req) begin
            state     <= S_EXEC;
            csr_ready <= 1'b0;
          end
        end
        S_EXEC: begin
          state     <= S_RESP;
          csr_ack   <= 1'b1;
          csr_rdata <= exec_err ? 32'h0 : old_val;
          csr_err   <= exec_err;
        end
        S_RESP: begin
          state     <= S_IDLE;
          csr_ready <= 1'b1;
          csr_ack   <= 1'b0;
          csr_rdata <= 32'h0;
          csr_err   <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          csr_ready <= 1'b1;
          csr_ack   <= 1'b0;
          csr_rdata <= 32'h0;
          csr_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_counter_ctrl.sv
// Directed bench for csr_counter_ctrl: stimulus pushes the hand-computed response
// into a scoreboard queue, a negedge monitor pops and compares on every ack.
module tb_csr_counter_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_req = 1'b0;
  logic [11:0] csr_addr = 12'h0;
  logic [1:0]  csr_mode = 2'b00;
  logic [31:0] csr_wdata = 32'h0;
  logic        instr_retire = 1'b0;
  logic        csr_ready;
  logic        csr_ack;
  logic [31:0] csr_rdata;
  logic        csr_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_total  = 0;
  int   n_pass   = 0;
  int   n_issued = 0;
  int   n_acks   = 0;
  bit   mon_en   = 1'b0;

  csr_counter_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .csr_req      (csr_req),
    .csr_addr     (csr_addr),
    .csr_mode     (csr_mode),
    .csr_wdata    (csr_wdata),
    .instr_retire (instr_retire),
    .csr_ready    (csr_ready),
    .csr_ack      (csr_ack),
    .csr_rdata    (csr_rdata),
    .csr_err      (csr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Monitor: every ack consumes one expected response; outside ack the data must be 0.
  always @(negedge clk) begin
    if (mon_en) begin
      if (csr_ack === 1'b1) begin
        n_acks++;
        check("ack_has_pending", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, "/rdata"}, csr_rdata, mon_e.rdata);
          check({mon_e.name, "/err"}, {31'h0, csr_err}, {31'h0, mon_e.err});
        end
      end else begin
        check("idle_rdata_zero", csr_rdata, 32'h0);
        check("idle_err_zero", {31'h0, csr_err}, 32'h0);
      end
    end
  end

  // One access starting in cycle T; returns #1 after the edge that begins T+3.
  task automatic access(input string name, input logic [11:0] addr, input logic [1:0] mode,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold = 1,
                        input logic retire_in_exec = 1'b0);
    int waited = 0;
    while (csr_ready !== 1'b1 && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    check({name, "/ready"}, {31'h0, csr_ready}, 32'd1);
    sb_q.push_back('{rdata: exp_rdata, err: exp_err, name: name});
    n_issued++;
    csr_req   = 1'b1;
    csr_addr  = addr;
    csr_mode  = mode;
    csr_wdata = wdata;
    @(posedge clk); #1;
    if (hold < 2) csr_req = 1'b0;
    instr_retire = retire_in_exec;
    check({name, "/exec_not_ready"}, {31'h0, csr_ready}, 32'd0);
    check({name, "/exec_no_ack"}, {31'h0, csr_ack}, 32'd0);
    @(posedge clk); #1;
    instr_retire = 1'b0;
    if (hold < 3) csr_req = 1'b0;
    check({name, "/ack_latency"}, {31'h0, csr_ack}, 32'd1);
    @(posedge clk); #1;
    csr_req = 1'b0;
  endtask

  task automatic pulse_retire(input int n);
    for (int i = 0; i < n; i++) begin
      instr_retire = 1'b1;
      @(posedge clk); #1;
      instr_retire = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_ready", {31'h0, csr_ready}, 32'd1);
    check("rst_ack", {31'h0, csr_ack}, 32'd0);
    check("rst_rdata", csr_rdata, 32'h0);
    check("rst_err", {31'h0, csr_err}, 32'd0);
    reset = 1'b0;                       // cycle C0, cyc=0
    repeat (10) @(posedge clk);
    #1;                                 // C10

    // Plain reads: rdata is the count during T+1.
    access("rd_mcycle",  12'hB00, 2'b00, 32'h0, 32'd11, 1'b0);
    access("rd_cycle",   12'hC00, 2'b00, 32'h0, 32'd14, 1'b0);
    access("rd_time",    12'hC01, 2'b00, 32'h0, 32'd17, 1'b0);
    access("rd_cycleh",  12'hC80, 2'b00, 32'h0, 32'd0,  1'b0);

    // Carry across halves: high half first, then low half close to wrap.
    access("wr_mcycleh", 12'hB80, 2'b01, 32'h0000_0005, 32'd0,  1'b0);
    access("wr_mcycle",  12'hB00, 2'b01, 32'hFFFF_FFFE, 32'd25, 1'b0);
    access("rd_cycleh6", 12'hC80, 2'b00, 32'h0, 32'd6, 1'b0);
    access("rd_mcycle_wrapped", 12'hB00, 2'b00, 32'h0, 32'd3, 1'b0);

    // mcountinhibit freezes both counters one cycle after commit.
    access("wr_inh5",    12'h320, 2'b01, 32'h5, 32'd0, 1'b0);
    access("rd_cyc_frz1", 12'hB00, 2'b00, 32'h0, 32'd7, 1'b0);
    access("rd_ins_frz1", 12'hB02, 2'b00, 32'h0, 32'd0, 1'b0);
    pulse_retire(1);
    access("rd_ins_frz2", 12'hB02, 2'b00, 32'h0, 32'd0, 1'b0);
    access("rd_cyc_frz2", 12'hB00, 2'b00, 32'h0, 32'd7, 1'b0);
    access("wr_inh7",    12'h320, 2'b01, 32'h7, 32'd5, 1'b0);
    access("rd_inh_bit1", 12'h320, 2'b00, 32'h0, 32'd5, 1'b0);
    access("wr_inh0",    12'h320, 2'b01, 32'h0, 32'd5, 1'b0);
    access("rd_cyc_resume", 12'hB00, 2'b00, 32'h0, 32'd9, 1'b0);

    // minstret write; a retire during the commit cycle is lost.
    access("wr_minstret", 12'hB02, 2'b01, 32'h10, 32'd0, 1'b0, 1, 1'b1);
    pulse_retire(3);
    access("rd_minstret", 12'hB02, 2'b00, 32'h0, 32'h13, 1'b0);
    access("rd_instreth", 12'hC82, 2'b00, 32'h0, 32'h0,  1'b0);
    access("rd_cyc_other", 12'hC00, 2'b00, 32'h0, 32'd27, 1'b0);

    // Error cases and pure reads of read-only addresses.
    access("wr_ro_cycle", 12'hC00, 2'b01, 32'h1234, 32'd0, 1'b1);
    access("rd_after_err", 12'hC00, 2'b00, 32'h0, 32'd33, 1'b0);
    access("set0_ro_cycle", 12'hC00, 2'b10, 32'h0, 32'd36, 1'b0);
    access("rd_unmapped", 12'h7FF, 2'b00, 32'h0, 32'd0, 1'b1);
    access("set_ro_instret", 12'hC02, 2'b10, 32'h1, 32'd0, 1'b1);
    access("clr_minstret", 12'hB02, 2'b11, 32'h3, 32'h13, 1'b0);
    access("rd_minstret_clr", 12'hB02, 2'b00, 32'h0, 32'h10, 1'b0);
    access("set_inh_cy", 12'h320, 2'b10, 32'h1, 32'd0, 1'b0);
    access("rd_cyc_frz3", 12'hB00, 2'b00, 32'h0, 32'd52, 1'b0);
    access("clr_inh_cy", 12'h320, 2'b11, 32'h1, 32'd1, 1'b0);
    access("rd_time_resume", 12'hC01, 2'b00, 32'h0, 32'd54, 1'b0);
    access("rd_timeh", 12'hC81, 2'b00, 32'h0, 32'd6, 1'b0);

    // Reset during EXEC of a cycleh write: no ack, write discarded.
    csr_req   = 1'b1;
    csr_addr  = 12'hB80;
    csr_mode  = 2'b01;
    csr_wdata = 32'h77;
    @(posedge clk); #1;
    csr_req = 1'b0;
    check("rstexec_in_exec", {31'h0, csr_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstexec_no_ack", {31'h0, csr_ack}, 32'd0);
    check("rstexec_ready", {31'h0, csr_ready}, 32'd1);
    reset = 1'b0;                       // new C0, cyc=0
    access("rd_cycleh_after_rst", 12'hB80, 2'b00, 32'h0, 32'd0, 1'b0);
    access("rd_mcycle_after_rst", 12'hB00, 2'b00, 32'h0, 32'd4, 1'b0);
    access("rd_inh_after_rst", 12'h320, 2'b00, 32'h0, 32'd0, 1'b0);
    access("rd_ins_after_rst", 12'hB02, 2'b00, 32'h0, 32'd0, 1'b0);

    // Request held high through EXEC and RESP is accepted once.
    access("rd_held_req", 12'hB00, 2'b00, 32'h0, 32'd13, 1'b0, 3);
    access("rd_after_held", 12'hB00, 2'b00, 32'h0, 32'd16, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("ack_count", 32'(n_acks), 32'(n_issued));
    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
